// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request per handshake, holds it for
// LATENCY cycles, then returns read data or an error flag from an internal array.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LOAD_CNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;

    logic        lat_wen;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        acc_wen;
    logic [3:0]  acc_wstrb;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic [29:0]           off_word;
    logic                  wrapped;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] idx;

    logic accept;
    logic enter_resp;

    logic [31:0] mem [DEPTH];

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // With LATENCY=1 the array access happens on the accept edge itself, so the
    // access fields bypass the latch while still in IDLE.
    always_comb begin
        if (state == IDLE) begin
            acc_wen   = req_wen;
            acc_wstrb = req_wstrb;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_wen   = lat_wen;
            acc_wstrb = lat_wstrb;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
        end
    end

    // Word offset computed as the upper bits of (addr - BASE_ADDR) with the borrow
    // from the low two bits, so an unaligned BASE_ADDR still maps correctly.
    always_comb begin
        wrapped      = acc_addr < BASE_ADDR;
        off_word     = acc_addr[31:2] - BASE_ADDR[31:2]
                       - 30'(acc_addr[1:0] < BASE_ADDR[1:0]);
        out_of_range = wrapped || ((off_word >> DEPTH_LOG2) != 30'd0);
        misaligned   = acc_addr[1:0] != 2'b00;
        acc_err      = out_of_range || misaligned;
        idx          = off_word[DEPTH_LOG2-1:0];
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next = LOAD_CNT;
                    if (LATENCY <= 1) state_next = RESP;
                    else              state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    cnt_next   = '0;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state != RESP) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_wen   <= req_wen;
            lat_wstrb <= req_wstrb;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || acc_wen) ? '0 : mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && acc_wen && !acc_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance at base 0 and a
// LATENCY=1 instance at base 0x100.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready, b_resp_err;
    logic [3:0]  b_req_wstrb;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_wstrb(b_req_wstrb), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Drives one request on the LATENCY=2 instance, waits (bounded) for the
    // response and returns it with the observed latency; completes the response
    // handshake only if resp_ready is already high.
    task automatic transact(input logic wen, input logic [3:0] st, input logic [31:0] a,
                            input logic [31:0] d, output resp_t got, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_wstrb = st; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = ~wen; req_wstrb = 4'hF;
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        got.rdata = resp_rdata;
        got.err   = resp_err;
        if (resp_ready && resp_valid) begin @(posedge clk); #1; end
    endtask

    task automatic run_seq(input string name, input logic wen, input logic [3:0] st,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rdata, input logic exp_err);
        resp_t got, e;
        int lat;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        transact(wen, st, a, d, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got rdata=%h err=%b, expected rdata=%h err=%b",
                     name, got.rdata, got.err, e.rdata, e.err);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL %s latency: got %0d, expected 2", name, lat);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_wstrb = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_wstrb = '0; b_req_addr = '0;
        b_req_wdata = '0; b_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'd0) begin
            errors++;
            $display("FAIL reset: got ready=%b valid=%b err=%b rdata=%h, expected all 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        checks++;
        if ({b_req_ready, b_resp_valid, b_resp_err, b_resp_rdata} !== 35'd0) begin
            errors++;
            $display("FAIL reset_lat1: got ready=%b valid=%b err=%b rdata=%h, expected all 0",
                     b_req_ready, b_resp_valid, b_resp_err, b_resp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_write_read;
        run_seq("write_deadbeef", 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run_seq("read_deadbeef",  1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        run_seq("write_word0",    1'b1, 4'hF, 32'h0, 32'h0123_4567, 32'h0, 1'b0);
        run_seq("read_word0",     1'b0, 4'h3, 32'h0, 32'hFFFF_FFFF, 32'h0123_4567, 1'b0);
        run_seq("write_last",     1'b1, 4'hF, 32'hFFC, 32'h0BAD_F00D, 32'h0, 1'b0);
        run_seq("read_last",      1'b0, 4'h0, 32'hFFC, 32'h0, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_byte_strobe;
        run_seq("write_full",     1'b1, 4'hF,    32'h20, 32'h1122_3344, 32'h0, 1'b0);
        run_seq("write_strb0101", 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 32'h0, 1'b0);
        run_seq("read_merged",    1'b0, 4'h0,    32'h20, 32'h0, 32'h11BB_33DD, 1'b0);
        run_seq("write_strb0",    1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_seq("read_after_strb0", 1'b0, 4'h0,  32'h20, 32'h0, 32'h11BB_33DD, 1'b0);
    endtask

    task automatic test_errors;
        run_seq("read_misaligned",  1'b0, 4'h0, 32'h13,   32'h0, 32'h0, 1'b1);
        run_seq("read_out_of_range", 1'b0, 4'h0, 32'h1000, 32'h0, 32'h0, 1'b1);
        run_seq("write_misaligned", 1'b1, 4'hF, 32'h13,   32'hFFFF_FFFF, 32'h0, 1'b1);
        run_seq("read_after_mis",   1'b0, 4'h0, 32'h10,   32'h0, 32'hDEAD_BEEF, 1'b0);
        run_seq("write_oor",        1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        run_seq("read_after_oor",   1'b0, 4'h0, 32'h0,    32'h0, 32'h0123_4567, 1'b0);
    endtask

    task automatic test_backpressure;
        resp_t got, e;
        int lat;
        resp_ready = 1'b0;
        exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        transact(1'b0, 4'h0, 32'h10, 32'h0, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL bp_response: got rdata=%h err=%b, expected rdata=%h err=%b",
                     got.rdata, got.err, e.rdata, e.err);
        end
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_valid, req_ready, resp_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b rdata=%h, expected 1 0 deadbeef",
                         i, resp_valid, req_ready, resp_rdata);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b, expected valid=0 ready=1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [4];
        resp_t e, got;
        int k, acc;
        logic took;
        addrs[0] = 32'h100; addrs[1] = 32'h80; addrs[2] = 32'h1100; addrs[3] = 32'h10FC;
        // Seed base word and last word of the LATENCY=1 instance.
        @(negedge clk);
        b_req_valid = 1'b1; b_req_wen = 1'b1; b_req_wstrb = 4'hF;
        b_req_addr = 32'h100; b_req_wdata = 32'h5A5A_1234;
        @(posedge clk); #1;
        b_req_addr = 32'h10FC; b_req_wdata = 32'h7777_0001;
        checks++;
        if ({b_resp_valid, b_resp_err} !== 2'b10) begin
            errors++;
            $display("FAIL lat1_valid_next_cycle: got valid=%b err=%b, expected 1 0",
                     b_resp_valid, b_resp_err);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_wen = 1'b0;
        k = 0; acc = 0;
        @(negedge clk);
        b_req_addr = addrs[0];
        for (int c = 0; c < 12; c++) begin
            if (b_resp_valid) begin
                got = '{rdata: b_resp_rdata, err: b_resp_err};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got rdata=%h err=%b, expected no response",
                             got.rdata, got.err);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL b2b_resp: got rdata=%h err=%b, expected rdata=%h err=%b",
                                 got.rdata, got.err, e.rdata, e.err);
                    end
                end
            end
            took = b_req_ready;
            if (took) begin
                acc++;
                case (b_req_addr)
                    32'h100:  exp_q.push_back('{rdata: 32'h5A5A_1234, err: 1'b0});
                    32'h10FC: exp_q.push_back('{rdata: 32'h7777_0001, err: 1'b0});
                    default:  exp_q.push_back('{rdata: 32'h0, err: 1'b1});
                endcase
            end
            @(negedge clk);
            if (took) begin k++; b_req_addr = addrs[k % 4]; end
        end
        b_req_valid = 1'b0;
        checks++;
        if (acc !== 6) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d accepts in 12 cycles, expected 6", acc);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_pending: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_drop;
        int seen;
        run_seq("write_cafe", 1'b1, 4'hF, 32'h40, 32'hCAFE_0040, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_wstrb = 4'hF; req_addr = 32'h40; req_wdata = 32'h5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset: got %b, expected 0", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL dropped_response: got %0d valid cycles, expected 0", seen);
        end
        run_seq("read_after_drop", 1'b0, 4'h0, 32'h40, 32'h0, 32'hCAFE_0040, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
